// File: rtl/pconv_c6_seq.sv
// Sequencer for the 6-channel pointwise convolution array: streams the feature map
// into the array and writes every 32-channel result to the output buffer.
module pconv_c6_seq #(
  parameter int N              = 16,
  parameter int INPUT_SIZE     = 6,
  parameter int OUTPUT_CHANNEL = 32,
  parameter int ADDR_W         = 6,
  parameter int ISSUE_GAP      = 1,
  parameter int TIMEOUT        = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        fm_rd_en,
  output logic [ADDR_W-1:0]           fm_rd_addr,
  input  logic [6*N-1:0]              fm_rd_data,
  output logic                        pc_input_vld,
  output logic [6*N-1:0]              pc_input_din,
  input  logic                        pc_dout_vld,
  input  logic [OUTPUT_CHANNEL*N-1:0] pc_dout,
  output logic                        ob_wr_en,
  output logic [ADDR_W-1:0]           ob_wr_addr,
  output logic [OUTPUT_CHANNEL*N-1:0] ob_wr_data
);

  localparam int P     = INPUT_SIZE * INPUT_SIZE;
  localparam int CW    = ADDR_W + 1;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]    P_CNT      = CW'(P);
  localparam logic [CW-1:0]    P_LAST     = CW'(P - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    rd_cnt, rd_cnt_nxt;
  logic [CW-1:0]    wr_cnt, wr_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic             err_nxt;
  logic             active;
  logic             rd_fire;
  logic             wr_fire;
  logic             unexpected;
  logic             vld_p1;

  // Stage p0: read issue and result capture decided combinationally from state
  assign active     = (state == ISSUE) || (state == DRAIN);
  assign rd_fire    = (state == ISSUE) && (gap_cnt == '0);
  assign wr_fire    = pc_dout_vld && active && (wr_cnt != P_CNT);
  assign unexpected = pc_dout_vld && !wr_fire;

  assign busy         = active;
  assign done         = (state == FIN);
  assign fm_rd_en     = rd_fire;
  assign fm_rd_addr   = rd_cnt[ADDR_W-1:0];
  assign pc_input_vld = vld_p1;
  assign pc_input_din = fm_rd_data;
  assign ob_wr_en     = wr_fire;
  assign ob_wr_addr   = wr_cnt[ADDR_W-1:0];
  assign ob_wr_data   = pc_dout;

  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    wr_cnt_nxt  = wr_fire ? wr_cnt + 1'b1 : wr_cnt;
    gap_cnt_nxt = gap_cnt;
    to_cnt_nxt  = to_cnt;
    err_nxt     = err | unexpected;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = ISSUE;
          err_nxt     = unexpected;
          rd_cnt_nxt  = '0;
          wr_cnt_nxt  = '0;
          gap_cnt_nxt = '0;
          to_cnt_nxt  = '0;
        end
      end
      ISSUE: begin
        if (rd_fire) begin
          rd_cnt_nxt  = rd_cnt + 1'b1;
          gap_cnt_nxt = GAP_RELOAD;
          if (rd_cnt == P_LAST) state_nxt = DRAIN;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      DRAIN: begin
        if (wr_cnt_nxt == P_CNT) begin
          state_nxt = FIN;
        end else if (pc_dout_vld) begin
          to_cnt_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          // Array went silent for TIMEOUT cycles: abandon the run without done
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered control state and the input-valid delay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      gap_cnt <= '0;
      to_cnt  <= '0;
      err     <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      wr_cnt  <= wr_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
      err     <= err_nxt;
      vld_p1  <= rd_fire;
    end
  end

endmodule

// File: doc/pconv_c6_seq.md
Name: pconv_c6_seq

Overview:
Sequencer for the 6-input-channel pointwise convolution array. On start it streams all INPUT_SIZE*INPUT_SIZE pixels (6 channels per word) from the feature-map buffer into the array. It counts the array's output-valid strobes and writes each 32-channel result to the output buffer at consecutive addresses. It reports done when all results are written, or an error on timeout or on unexpected outputs.

Parameters:
N, 16, data bit width per channel
INPUT_SIZE, 6, feature map side; P = INPUT_SIZE*INPUT_SIZE pixels
OUTPUT_CHANNEL, 32, output channels per result word
ADDR_W, 6, buffer address width; must satisfy 2^ADDR_W >= P
ISSUE_GAP, 1, cycles between successive pixel reads (>=1)
TIMEOUT, 255, max idle cycles waiting for an output in DRAIN

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  start request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done/err
done  out  1  one-cycle pulse when P results have been written
err  out  1  sticky error; cleared when start is accepted
fm_rd_en  out  1  feature-map buffer read strobe
fm_rd_addr  out  ADDR_W  feature-map read address
fm_rd_data  in  6*N  read data, valid 1 cycle after fm_rd_en
pc_input_vld  out  1  to array input_vld
pc_input_din  out  6*N  to array input_din; equals fm_rd_data
pc_dout_vld  in  1  from array conv_dout_vld
pc_dout  in  OUTPUT_CHANNEL*N  from array conv_dout
ob_wr_en  out  1  output buffer write strobe
ob_wr_addr  out  ADDR_W  output buffer write address
ob_wr_data  out  OUTPUT_CHANNEL*N  output buffer write data; equals pc_dout

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, all counters 0.
- Reset output values: busy=0, done=0, err=0, fm_rd_en=0, fm_rd_addr=0, pc_input_vld=0, ob_wr_en=0, ob_wr_addr=0.
- Reset mid-operation aborts immediately. No further reads or writes are issued.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 moves to ISSUE and clears err, rd_cnt, wr_cnt, gap_cnt and to_cnt.
- ISSUE reads: fm_rd_en=1 with fm_rd_addr=rd_cnt when gap_cnt==0. Then rd_cnt increments and gap_cnt reloads to ISSUE_GAP-1. Otherwise gap_cnt decrements.
- ISSUE exit: after the read with rd_cnt==P-1 is issued, move to DRAIN.
- pc_input_vld is fm_rd_en registered by one cycle. It is therefore high exactly P times per run, each in the cycle fm_rd_data is valid.
- pc_input_din is combinational from fm_rd_data.
- Output capture, in ISSUE or DRAIN:
  - pc_dout_vld=1 with wr_cnt<P gives ob_wr_en=1 (combinational), ob_wr_addr=wr_cnt and ob_wr_data=pc_dout in that cycle; wr_cnt increments.
  - Outputs may begin during ISSUE; array latency is unknown to this block.
- DRAIN: to_cnt increments each cycle without pc_dout_vld and resets to 0 on pc_dout_vld.
  - wr_cnt reaching P goes to FIN.
  - to_cnt reaching TIMEOUT sets err=1, drops busy and returns to IDLE with no done.
- FIN: done=1 for one cycle, busy=0 in the same cycle, next state IDLE.
- Unexpected outputs: pc_dout_vld in IDLE or FIN, or with wr_cnt==P, sets err=1 and is not written (ob_wr_en=0).
- start while not in IDLE is ignored. start held high restarts in the cycle after FIN→IDLE.
- Simultaneous read and write in one cycle is legal: independent counters, separate buffers.
- Counter widths: rd_cnt and wr_cnt are ADDR_W+1 bits so they can reach P without wrap. to_cnt is wide enough for TIMEOUT.

Test Plan:
1. Defaults, start one cycle, buffer words = pixel index, array modelled with latency 3 → 36 reads at addr 0..35 on consecutive cycles; 36 writes at ob_wr_addr 0..35 with data matching; done pulses once; err=0.
2. ISSUE_GAP=4 → fm_rd_en asserted every 4th cycle (36 pulses); pc_input_vld lags fm_rd_en by exactly 1 cycle.
3. Array model drops result 20 (35 outputs) → err=1 after 255 idle cycles in DRAIN; busy falls; no done; next start clears err.
4. Extra pc_dout_vld pulse after done → err=1; ob_wr_en stays 0.
5. rst_n=0 while rd_cnt=10 → next cycle busy=0 with no further fm_rd_en/ob_wr_en; a new start gives a clean run from addr 0.
6. start pulsed again during ISSUE → ignored; still exactly 36 reads and one done.
